// File: rtl/wb_queue_if.sv
// Bundles the upper-pipeline handshake and register-file writeback signals of wb_queue.
// The slave modport is the queue's view; the master modport is the surrounding pipeline's view.
`ifndef PC_RANGE
`define PC_RANGE 31:0
`endif
`ifndef PREG_RANGE
`define PREG_RANGE 5:0
`endif
`ifndef CX_TYPE_RANGE
`define CX_TYPE_RANGE 2:0
`endif
`ifndef MULDIV_TYPE_RANGE
`define MULDIV_TYPE_RANGE 3:0
`endif
`ifndef RESULT_RANGE
`define RESULT_RANGE 63:0
`endif

interface wb_queue_if;
  logic                        instr_valid_from_upper;
  logic                        instr_ready_to_upper;
  logic [`PC_RANGE]            pc;
  logic [`PREG_RANGE]          prd;
  logic                        need_to_wb;
  logic                        is_load;
  logic [`CX_TYPE_RANGE]       cx_type;
  logic [`MULDIV_TYPE_RANGE]   muldiv_type;
  logic [`RESULT_RANGE]        alu_result;
  logic [`RESULT_RANGE]        bju_result;
  logic [`RESULT_RANGE]        muldiv_result;
  logic [`RESULT_RANGE]        opload_read_data_wb;
  logic                        flush_valid;
  logic                        wb_grant;
  logic                        wb_valid;
  logic [`PREG_RANGE]          wb_prd;
  logic [`RESULT_RANGE]        wb_data;
  logic [`PC_RANGE]            wb_pc;

  modport slave (
    input  instr_valid_from_upper, pc, prd, need_to_wb, is_load, cx_type, muldiv_type,
           alu_result, bju_result, muldiv_result, opload_read_data_wb, flush_valid, wb_grant,
    output instr_ready_to_upper, wb_valid, wb_prd, wb_data, wb_pc
  );

  modport master (
    output instr_valid_from_upper, pc, prd, need_to_wb, is_load, cx_type, muldiv_type,
           alu_result, bju_result, muldiv_result, opload_read_data_wb, flush_valid, wb_grant,
    input  instr_ready_to_upper, wb_valid, wb_prd, wb_data, wb_pc
  );
endinterface

// File: rtl/wb_queue.sv
// Writeback queue: circular buffer between execute and the register-file write port.
// Optional macro WB_QUEUE_BYPASS_EN adds a same-cycle path from an empty queue to the write port.
module wb_queue #(
  parameter int DEPTH = 4
) (
  input logic       clock,
  input logic       reset,
  wb_queue_if.slave bus
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  typedef logic [PW-1:0] ptr_t;
  typedef logic [PW:0]   cnt_t;
  localparam cnt_t FULL = cnt_t'(DEPTH);

  ptr_t wr_ptr;
  ptr_t rd_ptr;
  cnt_t count;

  logic [`PREG_RANGE]   prd_mem  [DEPTH];
  logic [`RESULT_RANGE] data_mem [DEPTH];
  logic [`PC_RANGE]     pc_mem   [DEPTH];

  logic [`RESULT_RANGE] sel_data;
  logic q_valid;
  logic in_fire;
  logic bypass;
  logic push;
  logic pop;

  always_comb begin
    // NOTE: a default before the priority chain keeps every path assigned, so no latch is inferred.
    sel_data = bus.alu_result;
    if (bus.is_load)                 sel_data = bus.opload_read_data_wb;
    else if (bus.cx_type != '0)      sel_data = bus.bju_result;
    else if (bus.muldiv_type != '0)  sel_data = bus.muldiv_result;
  end

  assign q_valid                  = (count != '0) & ~bus.flush_valid;
  assign bus.instr_ready_to_upper = (count != FULL) & ~bus.flush_valid;
  assign in_fire                  = bus.instr_valid_from_upper & bus.instr_ready_to_upper;

`ifdef WB_QUEUE_BYPASS_EN
  assign bypass      = (count == '0) & in_fire & bus.need_to_wb & bus.wb_grant & ~bus.flush_valid;
  assign bus.wb_valid = q_valid | bypass;
  assign bus.wb_prd   = bypass ? bus.prd : prd_mem[rd_ptr];
  assign bus.wb_data  = bypass ? sel_data : data_mem[rd_ptr];
  assign bus.wb_pc    = bypass ? bus.pc : pc_mem[rd_ptr];
`else
  assign bypass       = 1'b0;
  assign bus.wb_valid = q_valid;
  assign bus.wb_prd   = prd_mem[rd_ptr];
  assign bus.wb_data  = data_mem[rd_ptr];
  assign bus.wb_pc    = pc_mem[rd_ptr];
`endif

  // in_fire already excludes flush, so a flushing cycle never writes or retires an entry.
  assign push = in_fire & bus.need_to_wb & ~bypass;
  assign pop  = q_valid & bus.wb_grant;

  always_ff @(posedge clock or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (bus.flush_valid) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + ptr_t'(1);
      if (pop)  rd_ptr <= rd_ptr + ptr_t'(1);
      case ({push, pop})
        2'b10:   count <= count + cnt_t'(1);
        2'b01:   count <= count - cnt_t'(1);
        default: count <= count;
      endcase
    end
  end

  // NOTE: payload storage has no reset; count and the pointers alone decide which entries are live.
  always_ff @(posedge clock) begin
    if (push) begin
      prd_mem[wr_ptr]  <= bus.prd;
      data_mem[wr_ptr] <= sel_data;
      pc_mem[wr_ptr]   <= bus.pc;
    end
  end
endmodule

// File: tb/tb_wb_queue.sv
// Randomized self-checking bench for wb_queue against a queue-based reference model.
`ifndef PC_RANGE
`define PC_RANGE 31:0
`endif
`ifndef PREG_RANGE
`define PREG_RANGE 5:0
`endif
`ifndef CX_TYPE_RANGE
`define CX_TYPE_RANGE 2:0
`endif
`ifndef MULDIV_TYPE_RANGE
`define MULDIV_TYPE_RANGE 3:0
`endif
`ifndef RESULT_RANGE
`define RESULT_RANGE 63:0
`endif

module tb_wb_queue;
  localparam int DEPTH = 4;

  typedef struct {
    logic [`PREG_RANGE]   prd;
    logic [`RESULT_RANGE] data;
    logic [`PC_RANGE]     pc;
  } entry_t;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   total = 0;
  int   bad   = 0;
  int   wb_seen = 0;
  entry_t model_q[$];

  wb_queue_if bus ();

  wb_queue #(.DEPTH(DEPTH)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [`RESULT_RANGE] pick_result();
    if (bus.is_load)                return bus.opload_read_data_wb;
    if (bus.cx_type != 0)           return bus.bju_result;
    if (bus.muldiv_type != 0)       return bus.muldiv_result;
    return bus.alu_result;
  endfunction

  task automatic idle_inputs();
    bus.instr_valid_from_upper = 1'b0;
    bus.need_to_wb  = 1'b0;
    bus.flush_valid = 1'b0;
    bus.wb_grant    = 1'b0;
    bus.is_load     = 1'b0;
    bus.cx_type     = '0;
    bus.muldiv_type = '0;
    bus.pc          = '0;
    bus.prd         = '0;
    bus.alu_result  = '0;
    bus.bju_result  = '0;
    bus.muldiv_result       = '0;
    bus.opload_read_data_wb = '0;
  endtask

  task automatic set_push(input logic [`PREG_RANGE] prd, input logic need, input logic grant);
    bus.instr_valid_from_upper = 1'b1;
    bus.prd        = prd;
    bus.pc         = 32'h1000 + 32'(prd) * 4;
    bus.need_to_wb = need;
    bus.wb_grant   = grant;
    bus.alu_result = 64'hA000 + 64'(prd);
  endtask

  // Called just after a falling edge with inputs already driven: checks outputs, then
  // advances the model across the next rising edge.
  task automatic cycle();
    bit     exp_ready, exp_valid, q_nonempty, fire, byp;
    entry_t head;
    #1;
    q_nonempty = (model_q.size() != 0);
    exp_ready  = (model_q.size() != DEPTH) && !bus.flush_valid;
    fire       = bus.instr_valid_from_upper && exp_ready;
    byp        = 1'b0;
`ifdef WB_QUEUE_BYPASS_EN
    byp = !q_nonempty && fire && bus.need_to_wb && bus.wb_grant && !bus.flush_valid;
`endif
    exp_valid = (q_nonempty && !bus.flush_valid) || byp;
    check("ready", 64'(bus.instr_ready_to_upper), 64'(exp_ready));
    check("wb_valid", 64'(bus.wb_valid), 64'(exp_valid));
    if (exp_valid) begin
      if (byp) head = '{prd: bus.prd, data: pick_result(), pc: bus.pc};
      else     head = model_q[0];
      check("wb_prd", 64'(bus.wb_prd), 64'(head.prd));
      check("wb_data", bus.wb_data, head.data);
      check("wb_pc", 64'(bus.wb_pc), 64'(head.pc));
    end
    @(posedge clock);
    if (bus.flush_valid) begin
      model_q.delete();
    end else begin
      if (exp_valid && bus.wb_grant) begin
        wb_seen++;
        if (!byp) void'(model_q.pop_front());
      end
      if (fire && bus.need_to_wb && !byp)
        model_q.push_back('{prd: bus.prd, data: pick_result(), pc: bus.pc});
    end
    @(negedge clock);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    check("rst_valid", 64'(bus.wb_valid), 64'd0);
    check("rst_ready", 64'(bus.instr_ready_to_upper), 64'd1);
    model_q.delete();
    @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
  endtask

  initial begin
    idle_inputs();
    @(negedge clock);
    do_reset();

    // Single entry: one-cycle latency, then empty again.
    set_push(6'd5, 1'b1, 1'b1);
    bus.alu_result = 64'h11;
    cycle();
    idle_inputs();
    bus.wb_grant = 1'b1;
`ifndef WB_QUEUE_BYPASS_EN
    check("lat_valid", 64'(bus.wb_valid), 64'd1);
    check("lat_prd", 64'(bus.wb_prd), 64'd5);
    check("lat_data", bus.wb_data, 64'h11);
`endif
    cycle();
    check("lat_drain", 64'(bus.wb_valid), 64'd0);

    // Fill to DEPTH with no grant, then drain in order.
    for (int i = 1; i <= DEPTH; i++) begin
      set_push(6'(i), 1'b1, 1'b0);
      cycle();
    end
    idle_inputs();
    check("full_ready", 64'(bus.instr_ready_to_upper), 64'd0);
    cycle();
    bus.wb_grant = 1'b1;
    for (int i = 1; i <= DEPTH; i++) begin
      check("drain_prd", 64'(bus.wb_prd), 64'(i));
      cycle();
      check("drain_ready", 64'(bus.instr_ready_to_upper), 64'd1);
    end

    // Result selection priority with distinct candidates.
    for (int k = 0; k < 4; k++) begin
      set_push(6'(10 + k), 1'b1, 1'b0);
      bus.opload_read_data_wb = 64'h1111;
      bus.bju_result          = 64'h2222;
      bus.muldiv_result       = 64'h3333;
      bus.alu_result          = 64'h4444;
      bus.is_load     = (k == 0);
      bus.cx_type     = (k == 1) ? 3'd1 : 3'd0;
      bus.muldiv_type = (k == 2) ? 4'd1 : 4'd0;
      cycle();
    end
    idle_inputs();
    bus.wb_grant = 1'b1;
    for (int k = 0; k < 4; k++) cycle();

    // Flush with three entries and a simultaneous push.
    idle_inputs();
    for (int i = 0; i < 3; i++) begin
      set_push(6'(20 + i), 1'b1, 1'b0);
      cycle();
    end
    set_push(6'd30, 1'b1, 1'b1);
    bus.flush_valid = 1'b1;
    cycle();
    idle_inputs();
    check("flush_valid", 64'(bus.wb_valid), 64'd0);
    cycle();

    // Alternating need_to_wb across more than DEPTH pushes.
    wb_seen = 0;
    for (int i = 0; i < 6; i++) begin
      set_push(6'(40 + i), 1'(i % 2 == 0), 1'b1);
      cycle();
    end
    idle_inputs();
    bus.wb_grant = 1'b1;
    for (int i = 0; i < 3; i++) cycle();
    check("alt_count", 64'(wb_seen), 64'd3);

    // Randomized traffic with occasional flushes and mid-operation resets.
    for (int n = 0; n < 600; n++) begin
      bus.instr_valid_from_upper = 1'($urandom_range(0, 3) != 0);
      bus.need_to_wb  = 1'($urandom_range(0, 3) != 0);
      bus.wb_grant    = 1'($urandom_range(0, 2) != 0);
      bus.flush_valid = 1'($urandom_range(0, 40) == 0);
      bus.is_load     = 1'($urandom_range(0, 3) == 0);
      bus.cx_type     = ($urandom_range(0, 2) == 0) ? 3'($urandom) : 3'd0;
      bus.muldiv_type = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'd0;
      bus.prd         = 6'($urandom);
      bus.pc          = $urandom;
      bus.alu_result          = {$urandom, $urandom};
      bus.bju_result          = {$urandom, $urandom};
      bus.muldiv_result       = {$urandom, $urandom};
      bus.opload_read_data_wb = {$urandom, $urandom};
      if (n % 150 == 149) begin
        bus.flush_valid = 1'b0;
        do_reset();
      end else begin
        cycle();
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/wb_queue.md
WB_QUEUE -- requirements
Module: wb_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, number of buffered writeback entries (power of two, at least 2).
REQ-002 SHALL have port clock  in  1  sole clock; all state changes on its rising edge.
REQ-003 SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-004 SHALL have port instr_valid_from_upper  in  1  execute pipeline register holds a valid instruction.
REQ-005 SHALL have port instr_ready_to_upper  out  1  queue can accept this cycle.
REQ-006 SHALL have port pc  in  `PC_RANGE  instruction PC.
REQ-007 SHALL have port prd  in  `PREG_RANGE  destination physical register.
REQ-008 SHALL have port need_to_wb  in  1  instruction writes a register.
REQ-009 SHALL have ports is_load  in  1, cx_type  in  `CX_TYPE_RANGE, muldiv_type  in  `MULDIV_TYPE_RANGE  result-source selectors.
REQ-010 SHALL have ports alu_result, bju_result, muldiv_result, opload_read_data_wb  in  `RESULT_RANGE  candidate results.
REQ-011 SHALL have port wb_grant  in  1  register-file write port is free this cycle.
REQ-012 SHALL have port wb_valid  out  1  writeback request.
REQ-013 SHALL have ports wb_prd  out  `PREG_RANGE, wb_data  out  `RESULT_RANGE, wb_pc  out  `PC_RANGE  writeback payload.
REQ-014 SHALL have port flush_valid  in  1  pipeline flush.

Function
REQ-015 Result select at enqueue, in priority order: is_load -> opload_read_data_wb; cx_type != 0 -> bju_result; muldiv_type != 0 -> muldiv_result; otherwise alu_result.
REQ-016 in_fire = instr_valid_from_upper & instr_ready_to_upper; an entry {prd, selected data, pc} is written only when in_fire & need_to_wb.
REQ-017 When in_fire & ~need_to_wb, the instruction is consumed and discarded, with no entry and no count change.
REQ-018 Storage is a circular buffer with wr_ptr, rd_ptr and count; pointers wrap from DEPTH-1 to 0.
REQ-019 instr_ready_to_upper = (count != DEPTH) & ~flush_valid, taken from registered state only and independent of wb_grant.
REQ-020 wb_valid = (count != 0) & ~flush_valid; wb_prd, wb_data and wb_pc present the rd_ptr entry.
REQ-021 Pop occurs when wb_valid & wb_grant; rd_ptr advances by 1 and count decrements.
REQ-022 Push and pop in the same cycle: both pointers advance and count is unchanged.
REQ-023 Enqueue-to-wb_valid latency is 1 cycle when the queue is empty.
REQ-024 Entries leave strictly in FIFO order.
REQ-025 While wb_valid=1 and wb_grant=0, the head payload holds stable.
REQ-026 flush_valid=1 clears count, wr_ptr and rd_ptr at the next edge; it overrides push and pop in that cycle, and no entry is written or retired.
REQ-027 The payload storage array is not cleared by flush or reset; only valid state is cleared.

Reset
REQ-028 Asserting reset immediately forces count=0, wr_ptr=0 and rd_ptr=0, so wb_valid=0 and instr_ready_to_upper=1.
REQ-029 Reset asserted mid-operation discards all buffered entries, with no writeback issued.
REQ-030 After release, the first accepted need_to_wb instruction appears on wb_valid one cycle later.

Configuration
REQ-031 Macro WB_QUEUE_BYPASS_EN enables the same-cycle bypass.
REQ-032 With WB_QUEUE_BYPASS_EN defined and count==0 & in_fire & need_to_wb & wb_grant & ~flush_valid:
- wb_valid=1 in the same cycle.
- Payload is the incoming selected data, prd and pc.
- No entry is written.
REQ-033 With WB_QUEUE_BYPASS_EN undefined, there is no combinational path from upper inputs to wb_* outputs, and REQ-023 latency applies always.

Verification
REQ-034 Reset, then push prd=5, alu_result=0x11, need_to_wb=1, wb_grant=1 -> next cycle wb_valid=1, wb_prd=5, wb_data=0x11; next cycle wb_valid=0.
REQ-035 wb_grant=0, push 4 entries prd=1..4 -> instr_ready_to_upper=0 after the fourth; raise wb_grant -> wb_prd 1,2,3,4 in successive cycles; ready returns 1 after the first pop.
REQ-036 Push one entry each with is_load=1, cx_type=1, muldiv_type=1 and plain ALU, all four result inputs distinct -> wb_data equals load, bju, muldiv and alu results respectively.
REQ-037 Queue holds 3 entries, then assert flush_valid together with a push -> next cycle wb_valid=0, count=0, pushed entry lost.
REQ-038 Push 6 entries with need_to_wb alternating 1/0, wb_grant=1 -> exactly 3 writebacks, in order; pointers wrap without loss across more than DEPTH total pushes.
REQ-039 With WB_QUEUE_BYPASS_EN, empty queue, push prd=7 with wb_grant=1 -> wb_valid=1, wb_prd=7 in the same cycle, and wb_valid=0 the following cycle.
